// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS32 memory responder and its benches.
//   state_t       : responder FSM states (IDLE, WAIT, ACCESS, RESP)
//   FETCH / DATA  : port-select encodings used by the arbiter
//   MIPS_DATA_W   : default word width
//   OP_LW / OP_SW : MIPS opcode field values for load/store word
// ----------------------------------------------------------------------------
package mips_pkg;

  localparam int MIPS_DATA_W = 32;

  // Port select values; also the encoding of the round-robin history bit.
  localparam logic FETCH = 1'b0;
  localparam logic DATA  = 1'b1;

  // MIPS32 primary opcode field values for the memory instructions.
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/mips_mem_responder_if.sv
// ----------------------------------------------------------------------------
// mips_mem_responder_if
// Request/acknowledge bus between the pipeline (master) and the memory
// responder (slave).
//   Fetch port : if_req, if_addr  -> if_ack, if_rdata
//   Data port  : dm_req, dm_we, dm_addr, dm_wdata -> dm_ack, dm_rdata
//   Status     : err (pulses with an ack for an out-of-range address),
//                busy (responder not idle)
// Requesters hold req high until they see the matching ack.
// ----------------------------------------------------------------------------
interface mips_mem_responder_if
  import mips_pkg::*;
#(
  parameter int DATA_W = MIPS_DATA_W
);

  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [31:0]       dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  logic              err;
  logic              busy;

  // Responder side.
  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output if_ack, if_rdata,
    output dm_ack, dm_rdata,
    output err, busy
  );

  // Pipeline side.
  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  if_ack, if_rdata,
    input  dm_ack, dm_rdata,
    input  err, busy
  );

endinterface

// File: rtl/mips_mem_array.sv
// ----------------------------------------------------------------------------
// mips_mem_array
// Single-port synchronous word RAM, DEPTH x DATA_W, with a registered read.
//   clk1     : clock, write and read register update on its rising edge
//   i_we     : write enable for i_addr
//   i_addr   : word index (AW bits)
//   i_wdata  : write data
//   o_rdata  : word at the address presented on the previous rising edge
//              (read-before-write on a simultaneous write)
// The array has no reset; its contents survive a responder reset.
// ----------------------------------------------------------------------------
module mips_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = 10
) (
  input  logic              clk1,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage plus read register; the read always samples the presented
  // address so the word is ready one cycle later whatever the caller does.
  always_ff @(posedge clk1) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mips_mem_responder.sv
// ----------------------------------------------------------------------------
// mips_mem_responder
// Memory-side responder for the MIPS32 pipeline. Arbitrates the fetch and
// data ports onto one single-ported word array with a fixed access time of
// WAIT_CYCLES + 3 cycles (grant, WAIT_CYCLES stalls, access, response) and a
// mandatory idle cycle between accesses.
//   clk1 : clock
//   rst  : asynchronous, active-high reset
//   bus  : mips_mem_responder_if.slave (fetch port, data port, err, busy)
// Parameters:
//   DATA_W      : word width
//   DEPTH       : array words; addresses >= DEPTH complete with err
//   WAIT_CYCLES : extra stall cycles per access (0..15)
// ----------------------------------------------------------------------------
module mips_mem_responder
  import mips_pkg::*;
#(
  parameter int DATA_W      = MIPS_DATA_W,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input logic                clk1,
  input logic                rst,
  mips_mem_responder_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Stall counter preload; unused when WAIT_CYCLES is zero.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t r_state;
  state_t w_nextState;

  logic              r_lastGrant;
  logic              r_sel;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_ifRdata;
  logic [DATA_W-1:0] r_dmRdata;

  logic              w_grantValid;
  logic              w_grantSel;
  logic [31:0]       w_grantAddr;
  logic              w_inRange;
  logic [AW-1:0]     w_ramAddr;
  logic              w_ramWe;
  logic [DATA_W-1:0] w_ramRdata;

  // Arbiter: a lone request wins outright; on a tie the port that did not
  // win last time is chosen, so neither port can be starved.
  always_comb begin
    w_grantValid = bus.if_req | bus.dm_req;
    w_grantSel   = FETCH;
    if (bus.if_req && bus.dm_req) begin
      w_grantSel = (r_lastGrant == DATA) ? FETCH : DATA;
    end else if (bus.dm_req) begin
      w_grantSel = DATA;
    end
    w_grantAddr = (w_grantSel == DATA) ? bus.dm_addr : bus.if_addr;
  end

  // Unsigned full-width compare; only the low AW bits reach the array.
  assign w_inRange = (r_addr < 32'(DEPTH));

  // In IDLE the RAM is pointed at the address about to be granted so that
  // its registered read is already valid in the ACCESS cycle, even when
  // there are no stall cycles.
  assign w_ramAddr = (r_state == IDLE) ? w_grantAddr[AW-1:0] : r_addr[AW-1:0];

  // Writes only happen on the ACCESS edge; a reset before it drops the store.
  assign w_ramWe = (r_state == ACCESS) && r_we && w_inRange;

  mips_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk1    (clk1),
    .i_we    (w_ramWe),
    .i_addr  (w_ramAddr),
    .i_wdata (r_wdata),
    .o_rdata (w_ramRdata)
  );

  // FSM state register.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next-state logic. RESP always returns to IDLE, which provides the
  // bubble that lets a requester drop req before it could be re-granted.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_grantValid) begin
          w_nextState = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_nextState = ACCESS;
        end
      end
      ACCESS:  w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Request latch, stall counter, round-robin history and read-data
  // registers. Request inputs are only looked at on the grant edge.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_lastGrant <= FETCH;
      r_sel       <= FETCH;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= 4'd0;
      r_ifRdata   <= '0;
      r_dmRdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantValid) begin
            r_lastGrant <= w_grantSel;
            r_sel       <= w_grantSel;
            r_addr      <= w_grantAddr;
            r_we        <= (w_grantSel == DATA) && bus.dm_we;
            r_wdata     <= bus.dm_wdata;
            r_cnt       <= WAIT_LOAD;
          end
        end
        WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ACCESS: begin
          // Out-of-range accesses return zero on either port, including
          // stores; in-range stores leave the read data untouched.
          if (!w_inRange) begin
            if (r_sel == DATA) begin
              r_dmRdata <= '0;
            end else begin
              r_ifRdata <= '0;
            end
          end else if (!r_we) begin
            if (r_sel == DATA) begin
              r_dmRdata <= w_ramRdata;
            end else begin
              r_ifRdata <= w_ramRdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // FSM outputs. Acks and err are decoded from RESP so that an asynchronous
  // reset clears them in the same instant it clears the state.
  always_comb begin
    bus.if_ack   = (r_state == RESP) && (r_sel == FETCH);
    bus.dm_ack   = (r_state == RESP) && (r_sel == DATA);
    bus.err      = (r_state == RESP) && !w_inRange;
    bus.busy     = (r_state != IDLE);
    bus.if_rdata = r_ifRdata;
    bus.dm_rdata = r_dmRdata;
  end

endmodule
